mor1kx_wb_mux_multi: RTL and testbench
======================================

MOR1KX_WB_MUX_MULTI -- requirements
Module: mor1kx_wb_mux_multi

Interface
REQ-001 Parameter OPTION_OPERAND_WIDTH, default 32: width of every data path.
REQ-002 Parameter NUM_SRC, default 4, legal 2..8: number of single-cycle result sources.
REQ-003 Parameter LATE_TIMEOUT, default 64, legal 2..255: maximum cycles spent waiting for a late result.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port src_data_i, input, NUM_SRC*OPTION_OPERAND_WIDTH: packed early-source results; source k occupies bits [k*W +: W].
REQ-007 Port src_sel_i, input, NUM_SRC: one-hot select of the early source.
REQ-008 Port issue_i, input, 1: an instruction enters writeback this cycle.
REQ-009 Port late_sel_i, input, 1: the issued instruction takes its result from the late (multi-cycle) unit.
REQ-010 Port late_data_i, input, OPTION_OPERAND_WIDTH: late-unit result.
REQ-011 Port late_valid_i, input, 1: late_data_i is valid this cycle.
REQ-012 Port flush_i, input, 1: abort any pending writeback.
REQ-013 Port rf_result_o, output, OPTION_OPERAND_WIDTH: registered register-file write data.
REQ-014 Port rf_we_o, output, 1: one-cycle register-file write-enable pulse.
REQ-015 Port busy_o, output, 1: block is waiting on a late result.
REQ-016 Port timeout_o, output, 1: one-cycle pulse when the late wait expires.
REQ-017 Port sel_err_o, output, 1: registered select-error flag.

Function
REQ-018 States SHALL be IDLE and WAIT_LATE; busy_o SHALL be 1 exactly in WAIT_LATE.
REQ-019 In IDLE, issue_i=1 with late_sel_i=0 SHALL register the early source named by src_sel_i into rf_result_o and assert rf_we_o on the next cycle (latency 1).
REQ-020 In IDLE, issue_i=1 with late_sel_i=1 and late_valid_i=1 SHALL register late_data_i and pulse rf_we_o on the next cycle, with the FSM remaining in IDLE.
REQ-021 In IDLE, issue_i=1 with late_sel_i=1 and late_valid_i=0 SHALL go to WAIT_LATE and clear the wait counter.
REQ-022 In WAIT_LATE, late_valid_i=1 SHALL register late_data_i, pulse rf_we_o on the next cycle and return to IDLE.
REQ-023 In WAIT_LATE the wait counter SHALL increment each cycle; reaching LATE_TIMEOUT-1 with no late_valid_i SHALL return to IDLE, pulse timeout_o and give no rf_we_o.
REQ-024 issue_i while in WAIT_LATE SHALL be ignored: no state, data or write-enable change.
REQ-025 late_valid_i while in IDLE without a late issue SHALL be ignored.
REQ-026 flush_i SHALL have priority over every other event: force IDLE, rf_we_o=0 on the next cycle, and no timeout_o pulse.
REQ-027 Simultaneous flush_i and late_valid_i SHALL discard the late result.
REQ-028 rf_result_o SHALL hold its last written value whenever rf_we_o=0.
REQ-029 Early-source selection SHALL be an AND-OR over src_sel_i; a zero select SHALL yield 0, and a multi-hot select SHALL yield the OR of the selected sources.
REQ-030 rf_we_o and timeout_o SHALL never both be 1 in the same cycle.

Reset
REQ-031 Asserting rst SHALL immediately force IDLE, wait counter 0, rf_result_o=0, rf_we_o=0, busy_o=0, timeout_o=0 and sel_err_o=0.
REQ-032 Reset asserted while in WAIT_LATE SHALL drop the pending result; a late_valid_i arriving after reset release SHALL be ignored.

Configuration
REQ-033 Macro MOR1KX_WB_MUX_SELCHK_EN defined: sel_err_o SHALL be set one cycle after an early issue whose src_sel_i is not exactly one-hot, and SHALL stay set until rst.
REQ-034 Macro MOR1KX_WB_MUX_SELCHK_EN undefined: sel_err_o SHALL be tied to 0 and no check logic SHALL be present.

Verification
REQ-035 NUM_SRC=4, src_sel_i=4'b0100, src2=0x1234_5678, issue_i for 1 cycle -> next cycle rf_result_o=0x1234_5678 and rf_we_o=1 for exactly 1 cycle.
REQ-036 Late issue, then late_valid_i 5 cycles later with 0xDEAD_BEEF -> busy_o high for 5 cycles, then rf_result_o=0xDEAD_BEEF with a single rf_we_o pulse.
REQ-037 LATE_TIMEOUT=8, late issue and late_valid_i never asserted -> timeout_o pulses once 8 cycles after issue, with no rf_we_o and busy_o=0 afterwards.
REQ-038 In WAIT_LATE, flush_i and late_valid_i asserted in the same cycle -> no rf_we_o, IDLE, and rf_result_o unchanged.
REQ-039 With MOR1KX_WB_MUX_SELCHK_EN defined, src_sel_i=4'b0011 on issue -> sel_err_o=1 next cycle, remaining 1 until rst, and rf_result_o=src0|src1.
REQ-040 rst asserted mid-WAIT_LATE, then late_valid_i after release -> all outputs 0 and no rf_we_o.

Source files
------------

// File: rtl/mor1kx_wb_mux_multi.sv
// mor1kx_wb_mux_multi: writeback mux for single-cycle sources plus one late unit, with timeout
// Define MOR1KX_WB_MUX_SELCHK_EN to enable the sticky non-one-hot select error flag.
module mor1kx_wb_mux_multi #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int NUM_SRC = 4,
  parameter int LATE_TIMEOUT = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_SRC*OPTION_OPERAND_WIDTH-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]                      src_sel_i,
  input  logic                                    issue_i,
  input  logic                                    late_sel_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]         late_data_i,
  input  logic                                    late_valid_i,
  input  logic                                    flush_i,
  output logic [OPTION_OPERAND_WIDTH-1:0]         rf_result_o,
  output logic                                    rf_we_o,
  output logic                                    busy_o,
  output logic                                    timeout_o,
  output logic                                    sel_err_o
);
  localparam int W = OPTION_OPERAND_WIDTH;
  typedef enum logic {IDLE, WAIT_LATE} state_t;
  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [W-1:0] early_data, res_nxt;
  logic we_nxt, to_nxt;
  always_comb begin
    early_data = '0;
    for (int k = 0; k < NUM_SRC; k++)
      early_data = early_data | (src_data_i[k*W +: W] & {W{src_sel_i[k]}});
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    we_nxt = 1'b0;
    to_nxt = 1'b0;
    res_nxt = rf_result_o;
    if (flush_i) begin
      state_nxt = IDLE;
      cnt_nxt = '0;
    end else if (state == IDLE) begin
      if (issue_i && !late_sel_i) begin
        we_nxt = 1'b1;
        res_nxt = early_data;
      end else if (issue_i && late_valid_i) begin
        we_nxt = 1'b1;
        res_nxt = late_data_i;
      end else if (issue_i) begin
        state_nxt = WAIT_LATE;
        cnt_nxt = '0;
      end
    end else if (late_valid_i) begin
      state_nxt = IDLE;
      we_nxt = 1'b1;
      res_nxt = late_data_i;
    end else if (cnt == 8'(LATE_TIMEOUT - 1)) begin
      state_nxt = IDLE;
      to_nxt = 1'b1;
    end else begin
      cnt_nxt = cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rf_result_o <= '0;
      rf_we_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      rf_result_o <= res_nxt;
      rf_we_o <= we_nxt;
      timeout_o <= to_nxt;
    end
  end
  assign busy_o = (state == WAIT_LATE);
`ifdef MOR1KX_WB_MUX_SELCHK_EN
  logic sel_bad;
  assign sel_bad = (src_sel_i == '0) || ((src_sel_i & (src_sel_i - 1'b1)) != '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_err_o <= 1'b0;
    else if (!flush_i && state == IDLE && issue_i && !late_sel_i && sel_bad) sel_err_o <= 1'b1;
  end
`else
  assign sel_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_mor1kx_wb_mux_multi.sv
// tb_mor1kx_wb_mux_multi: directed vector table plus hand-written late/timeout/flush/reset sequences
module tb_mor1kx_wb_mux_multi;
`ifdef MOR1KX_WB_MUX_SELCHK_EN
  localparam logic SELCHK = 1'b1;
`else
  localparam logic SELCHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] src_sel_i = '0;
  logic issue_i = 0, late_sel_i = 0, late_valid_i = 0, flush_i = 0;
  logic [31:0] late_data_i = '0;
  logic [31:0] rf_result_o;
  logic rf_we_o, busy_o, timeout_o, sel_err_o;
  logic [31:0] src0 = 32'h0000_00F0, src1 = 32'h0000_0F00, src2 = 32'h1234_5678, src3 = 32'hA5A5_0000;
  int checks = 0, fails = 0;

  mor1kx_wb_mux_multi #(.OPTION_OPERAND_WIDTH(32), .NUM_SRC(4), .LATE_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .src_data_i({src3, src2, src1, src0}), .src_sel_i(src_sel_i),
    .issue_i(issue_i), .late_sel_i(late_sel_i), .late_data_i(late_data_i),
    .late_valid_i(late_valid_i), .flush_i(flush_i), .rf_result_o(rf_result_o),
    .rf_we_o(rf_we_o), .busy_o(busy_o), .timeout_o(timeout_o), .sel_err_o(sel_err_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic issue, late, valid, flush;
    logic [31:0] ldata, res;
    logic we, busy, err;
  } vec_t;
  vec_t v[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic iss, input logic lt, input logic vl,
                       input logic fl, input logic [31:0] ld);
    src_sel_i = sel; issue_i = iss; late_sel_i = lt; late_valid_i = vl; flush_i = fl; late_data_i = ld;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(4'b0, 0, 0, 0, 0, 32'h0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    v[0]  = '{4'b0100, 1, 0, 0, 0, 32'h0, 32'h1234_5678, 1, 0, 0};
    v[1]  = '{4'b0000, 0, 0, 0, 0, 32'h0, 32'h1234_5678, 0, 0, 0};
    v[2]  = '{4'b0001, 1, 0, 0, 0, 32'h0, 32'h0000_00F0, 1, 0, 0};
    v[3]  = '{4'b0000, 1, 0, 0, 0, 32'h0, 32'h0000_0000, 1, 0, 1};
    v[4]  = '{4'b0000, 1, 1, 1, 0, 32'hCAFE_0001, 32'hCAFE_0001, 1, 0, 1};
    v[5]  = '{4'b0000, 0, 0, 1, 0, 32'h0000_0055, 32'hCAFE_0001, 0, 0, 1};
    v[6]  = '{4'b0000, 1, 1, 0, 0, 32'h0, 32'hCAFE_0001, 0, 1, 1};
    v[7]  = '{4'b0100, 1, 0, 0, 0, 32'h0, 32'hCAFE_0001, 0, 1, 1};
    v[8]  = '{4'b0000, 0, 0, 1, 0, 32'h0000_0077, 32'h0000_0077, 1, 0, 1};
    v[9]  = '{4'b0100, 1, 0, 0, 1, 32'h0, 32'h0000_0077, 0, 0, 1};
    v[10] = '{4'b1000, 1, 0, 0, 0, 32'h0, 32'hA5A5_0000, 1, 0, 1};
    v[11] = '{4'b0011, 1, 0, 0, 0, 32'h0, 32'h0000_0FF0, 1, 0, 1};

    step();
    chk("reset_result", rf_result_o, 32'h0);
    chk("reset_we", {31'b0, rf_we_o}, 32'h0);
    chk("reset_busy", {31'b0, busy_o}, 32'h0);
    chk("reset_timeout", {31'b0, timeout_o}, 32'h0);
    chk("reset_selerr", {31'b0, sel_err_o}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(v[i].sel, v[i].issue, v[i].late, v[i].valid, v[i].flush, v[i].ldata);
      step();
      chk($sformatf("vec%0d_result", i), rf_result_o, v[i].res);
      chk($sformatf("vec%0d_we", i), {31'b0, rf_we_o}, {31'b0, v[i].we});
      chk($sformatf("vec%0d_busy", i), {31'b0, busy_o}, {31'b0, v[i].busy});
      chk($sformatf("vec%0d_timeout", i), {31'b0, timeout_o}, 32'h0);
      chk($sformatf("vec%0d_selerr", i), {31'b0, sel_err_o}, {31'b0, v[i].err & SELCHK});
    end
    drive(4'b0, 0, 0, 0, 0, 32'h0);
    step();
    chk("selerr_sticky", {31'b0, sel_err_o}, {31'b0, SELCHK});
    chk("hold_after_we", rf_result_o, 32'h0000_0FF0);
    do_reset();
    chk("selerr_cleared", {31'b0, sel_err_o}, 32'h0);

    begin : late_5
      int busy_cycles = 0, we_cnt = 0;
      drive(4'b0, 1, 1, 0, 0, 32'h0);
      step();
      busy_cycles += int'(busy_o);
      for (int c = 0; c < 4; c++) begin
        drive(4'b0, 0, 0, 0, 0, 32'h0);
        step();
        busy_cycles += int'(busy_o);
        we_cnt += int'(rf_we_o);
      end
      drive(4'b0, 0, 0, 1, 0, 32'hDEAD_BEEF);
      step();
      we_cnt += int'(rf_we_o);
      chk("late5_busy_cycles", busy_cycles, 5);
      chk("late5_result", rf_result_o, 32'hDEAD_BEEF);
      chk("late5_busy_after", {31'b0, busy_o}, 32'h0);
      drive(4'b0, 0, 0, 0, 0, 32'h0);
      step();
      we_cnt += int'(rf_we_o);
      chk("late5_we_pulses", we_cnt, 1);
    end

    begin : timeout_8
      int to_cnt = 0, we_cnt = 0, to_at = -1;
      drive(4'b0, 1, 1, 0, 0, 32'h0);
      step();
      drive(4'b0, 0, 0, 0, 0, 32'h0);
      for (int c = 1; c <= 10; c++) begin
        step();
        if (timeout_o) begin to_cnt++; to_at = c; end
        we_cnt += int'(rf_we_o);
        if (c == 8) chk("timeout_busy_cleared", {31'b0, busy_o}, 32'h0);
        if (c == 7) chk("timeout_busy_before", {31'b0, busy_o}, 32'h1);
      end
      chk("timeout_pulses", to_cnt, 1);
      chk("timeout_cycle", to_at, 8);
      chk("timeout_no_we", we_cnt, 0);
      chk("timeout_result_held", rf_result_o, 32'hDEAD_BEEF);
    end

    drive(4'b0, 1, 1, 0, 0, 32'h0);
    step();
    chk("flush_wait_busy", {31'b0, busy_o}, 32'h1);
    drive(4'b0, 0, 0, 1, 1, 32'h0000_0099);
    step();
    chk("flush_valid_we", {31'b0, rf_we_o}, 32'h0);
    chk("flush_valid_busy", {31'b0, busy_o}, 32'h0);
    chk("flush_valid_result", rf_result_o, 32'hDEAD_BEEF);
    drive(4'b0, 0, 0, 1, 0, 32'h0000_0099);
    step();
    chk("flush_late_ignored_we", {31'b0, rf_we_o}, 32'h0);

    drive(4'b0, 1, 1, 0, 0, 32'h0);
    step();
    drive(4'b0, 0, 0, 0, 0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", {31'b0, busy_o}, 32'h0);
    chk("async_rst_result", rf_result_o, 32'h0);
    step();
    rst = 1'b0;
    drive(4'b0, 0, 0, 1, 0, 32'h1111_2222);
    step();
    chk("rst_wait_we", {31'b0, rf_we_o}, 32'h0);
    chk("rst_wait_result", rf_result_o, 32'h0);
    chk("rst_wait_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_wait_timeout", {31'b0, timeout_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  always @(negedge clk) if (!rst && rf_we_o && timeout_o) begin
    fails++;
    checks++;
    $display("FAIL we_timeout_exclusive: rf_we_o=%b timeout_o=%b expected not both 1", rf_we_o, timeout_o);
  end
endmodule
